// File: rtl/div_pkg.sv
// Shared constants for the EX-stage multi-cycle units (multiplier and divider).
// Holds the legacy 2-bit state encodings and common control-level constants.
package div_pkg;

    // Control-level constants reused across the pipeline.
    localparam logic        RstEnable = 1'b1;
    localparam logic        Flush     = 1'b1;
    localparam logic        Exception = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Multiplier FSM encodings (2-cycle Booth/CSA unit).
    localparam logic [1:0]  MUL_IDLE  = 2'b00;
    localparam logic [1:0]  MUL_ON    = 2'b01;

    // Divider FSM encodings.
    localparam logic [1:0]  DIV_IDLE  = 2'b00;
    localparam logic [1:0]  DIV_ON    = 2'b01;
    localparam logic [1:0]  DIV_END   = 2'b10;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      - current partial remainder (WIDTH+1 bits)
//   dvd_bit  - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   rem_next - partial remainder after the step
//   q_bit    - quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    // Shift is carried out at full width so no remainder bit is discarded;
    // the top bit is always 0 in practice since rem < divisor.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {2'b00, divisor};
        q_bit    = (shifted >= {2'b00, divisor});
        rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring integer divider (DIV/DIVU) for the EX stage.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   flush, flush_cause - pipeline flush; cause 1 (exception) aborts the division
//   request            - start a division, sampled only while idle
//   x, y, s            - dividend, divisor, signed select
//   ready              - one-cycle pulse, z valid
//   busy               - high from accept edge through the ready pulse
//   z                  - {remainder, quotient}
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               flush_cause,
    input  logic               request,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               s,
    output logic               ready,
    output logic               busy,
    output logic [2*WIDTH-1:0] z
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             abort;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic n);
        return n ? ('0 - v) : v;
    endfunction

    assign abort = (flush == Flush) && (flush_cause == Exception);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // The dividend register doubles as the quotient register: each step
    // shifts one dividend bit out at the top and one quotient bit in at the
    // bottom, so after WIDTH steps it holds the unsigned quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            z      <= '0;
        end else if (abort) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    ready <= 1'b0;
                    if (request) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (y == '0) begin
                            // Divide-by-zero: fixed result, signs bypassed.
                            dvd    <= '1;
                            rem    <= {1'b0, x};
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                            state  <= DIV_END;
                        end else begin
                            dvd    <= neg_if(x, s & x[WIDTH-1]);
                            dsr    <= neg_if(y, s & y[WIDTH-1]);
                            rem    <= '0;
                            sign_q <= s & (x[WIDTH-1] ^ y[WIDTH-1]);
                            sign_r <= s & x[WIDTH-1];
                            state  <= DIV_ON;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DIV_ON: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DIV_END;
                    end
                end
                DIV_END: begin
                    z     <= {neg_if(rem[WIDTH-1:0], sign_r), neg_if(dvd, sign_q)};
                    ready <= 1'b1;
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases, randomized operations
// against a plain-arithmetic reference, flush/abort, ignored requests and reset.
module tb_div;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        flush_cause;
    logic        request;
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic        ready;
    logic        busy;
    logic [63:0] z;

    int tests_run = 0;
    int failed    = 0;
    logic [63:0] last_z = '0;

    div #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .flush_cause (flush_cause),
        .request     (request),
        .x           (x),
        .y           (y),
        .s           (s),
        .ready       (ready),
        .busy        (busy),
        .z           (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit integer division, truncating toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one request, optionally flushes or re-requests mid-operation,
    // and reports what was observed. lat = cycles from accept to ready (0 = none).
    task automatic do_op(input logic [31:0] xa, input logic [31:0] ya, input logic sa,
                         input int fl_at, input logic fl_cause, input int tog_at,
                         output logic [63:0] zo, output int lat, output bit busy_ok,
                         output bit pulse_ok, output logic bf);
        int n;
        zo = '0; lat = 0; busy_ok = 1; pulse_ok = 1; bf = 1'b1;
        @(negedge clk);
        x = xa; y = ya; s = sa; request = 1'b1;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == fl_at + 1) bf = busy;
            if (ready) begin
                lat = n;
                if (!busy) busy_ok = 0;
                break;
            end
            if (!busy && (fl_at == 0 || n <= fl_at)) busy_ok = 0;
            request     = (n == tog_at);
            flush       = (n == fl_at);
            flush_cause = fl_cause;
            if (n == 1 || n == tog_at) begin
                x = $urandom; y = $urandom; s = $urandom_range(0, 1);
            end
        end
        request = 1'b0; flush = 1'b0; flush_cause = 1'b0;
        zo = z;
        @(negedge clk);
        if (ready) pulse_ok = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; flush_cause = 1'b0; request = 1'b0;
        x = '0; y = '0; s = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (ready !== 1'b0) begin failed++; $display("FAIL reset_ready got=%b exp=0", ready); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (z !== 64'd0) begin failed++; $display("FAIL reset_z got=%h exp=0", z); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] xs [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] ys [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic        ss [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] ex [6] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                {32'd1, 32'hFFFF_FFFD}, {32'h1234_5678, 32'hFFFF_FFFF},
                                {32'd0, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}};
        logic [63:0] zo; int lat, exp_lat; bit bok, pok; logic bf;
        for (int i = 0; i < 6; i++) begin
            do_op(xs[i], ys[i], ss[i], 0, 1'b0, 0, zo, lat, bok, pok, bf);
            exp_lat = (ys[i] == 0) ? 2 : 34;
            tests_run++; if (zo !== ex[i]) begin failed++; $display("FAIL directed_z[%0d] got=%h exp=%h", i, zo, ex[i]); end
            tests_run++; if (zo !== ref_div(xs[i], ys[i], ss[i])) begin failed++; $display("FAIL directed_model[%0d] got=%h exp=%h", i, zo, ref_div(xs[i], ys[i], ss[i])); end
            tests_run++; if (lat !== exp_lat) begin failed++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            tests_run++; if (!bok) begin failed++; $display("FAIL directed_busy[%0d] got=low exp=high", i); end
            tests_run++; if (!pok) begin failed++; $display("FAIL directed_pulse[%0d] got=ready_twice exp=one_cycle", i); end
            last_z = zo;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b; logic sg; logic [63:0] zo; int lat, exp_lat, sel; bit bok, pok; logic bf;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; sg = $urandom_range(0, 1);
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel < 3) b = $urandom_range(1, 20);
            else if (sel == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            do_op(a, b, sg, 0, 1'b0, 0, zo, lat, bok, pok, bf);
            exp_lat = (b == 0) ? 2 : 34;
            tests_run++; if (zo !== ref_div(a, b, sg)) begin failed++; $display("FAIL random_z x=%h y=%h s=%b got=%h exp=%h", a, b, sg, zo, ref_div(a, b, sg)); end
            tests_run++; if (lat !== exp_lat) begin failed++; $display("FAIL random_lat got=%0d exp=%0d", lat, exp_lat); end
            last_z = zo;
        end
    endtask

    task automatic test_flush();
        logic [63:0] zo; int lat; bit bok, pok; logic bf;
        do_op(32'd1234, 32'd3, 1'b0, 10, 1'b1, 0, zo, lat, bok, pok, bf);
        tests_run++; if (lat !== 0) begin failed++; $display("FAIL abort_ready got_lat=%0d exp=0", lat); end
        tests_run++; if (bf !== 1'b0) begin failed++; $display("FAIL abort_busy got=%b exp=0", bf); end
        tests_run++; if (zo !== last_z) begin failed++; $display("FAIL abort_z got=%h exp=%h", zo, last_z); end
        do_op(32'd50, 32'd5, 1'b0, 0, 1'b0, 0, zo, lat, bok, pok, bf);
        tests_run++; if (zo !== 64'd10) begin failed++; $display("FAIL after_abort_z got=%h exp=%h", zo, 64'd10); end
        tests_run++; if (lat !== 34) begin failed++; $display("FAIL after_abort_lat got=%0d exp=34", lat); end
        do_op(32'd1000, 32'd7, 1'b0, 5, 1'b0, 0, zo, lat, bok, pok, bf);
        tests_run++; if (zo !== ref_div(32'd1000, 32'd7, 1'b0)) begin failed++; $display("FAIL flush_cause0_z got=%h exp=%h", zo, ref_div(32'd1000, 32'd7, 1'b0)); end
        tests_run++; if (lat !== 34) begin failed++; $display("FAIL flush_cause0_lat got=%0d exp=34", lat); end
        last_z = zo;
        // Exception flush in the same cycle as a request: nothing is accepted.
        @(negedge clk);
        x = 32'd9; y = 32'd3; s = 1'b0; request = 1'b1; flush = 1'b1; flush_cause = 1'b1;
        @(negedge clk);
        request = 1'b0; flush = 1'b0; flush_cause = 1'b0;
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL flush_wins_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        tests_run++; if (ready !== 1'b0 || z !== last_z) begin failed++; $display("FAIL flush_wins_z got=%h/%b exp=%h/0", z, ready, last_z); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] zo; int lat; bit bok, pok; logic bf;
        do_op(32'd999, 32'd4, 1'b0, 0, 1'b0, 12, zo, lat, bok, pok, bf);
        tests_run++; if (zo !== {32'd3, 32'd249}) begin failed++; $display("FAIL busy_request_z got=%h exp=%h", zo, {32'd3, 32'd249}); end
        tests_run++; if (lat !== 34) begin failed++; $display("FAIL busy_request_lat got=%0d exp=34", lat); end
        last_z = zo;
    endtask

    task automatic test_reset_midop();
        logic [63:0] zo; int lat; bit bok, pok; logic bf;
        @(negedge clk);
        x = 32'd77; y = 32'd5; s = 1'b0; request = 1'b1;
        @(negedge clk);
        request = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++; if (ready !== 1'b0 || busy !== 1'b0 || z !== 64'd0) begin failed++; $display("FAIL midop_reset got=%b/%b/%h exp=0/0/0", ready, busy, z); end
        @(negedge clk);
        rst = 1'b0;
        do_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, 1'b0, 0, zo, lat, bok, pok, bf);
        tests_run++; if (zo !== ref_div(32'hFFFF_FF9C, 32'd7, 1'b1)) begin failed++; $display("FAIL post_reset_z got=%h exp=%h", zo, ref_div(32'hFFFF_FF9C, 32'd7, 1'b1)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
